// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared fetch types, constants and helpers
package riscv_fetch_pkg;

  localparam int          FETCH_XLEN  = 32;
  localparam int          MAX_LATENCY = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
    logic                  fault;
  } fetch_entry_t;

  function automatic logic [2:0] count_inflight(input logic [MAX_LATENCY-1:0] valid);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < MAX_LATENCY; i++) begin
      n = n + 3'(valid[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous show-ahead FIFO with flush
module fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count == '0);
  assign count_o = count;
  assign data_o  = mem[rd_ptr];
  assign do_push = push_i && (count < CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// rtl/instr_fetch_buffer.sv - fetch PC, instruction array, read pipeline and prefetch FIFO
module instr_fetch_buffer
  import riscv_fetch_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter int               DEPTH        = 256,
  parameter string            IN_FILE      = "./programs/test_add.hex",
  parameter logic [XLEN-1:0]  RESET_PC     = '0,
  parameter int               READ_LATENCY = 1,
  parameter int               FIFO_DEPTH   = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            fault_o
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            fault;
  } entry_t;

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] mem [DEPTH];

  logic [XLEN-1:0]        fetch_pc;
  logic [XLEN-1:0]        index;
  logic                   halt;
  logic                   bad_addr;
  logic                   issue;
  entry_t                 issue_entry;
  logic                   wr_valid;
  entry_t                 wr_entry;
  logic [MAX_LATENCY-1:0] pipe_valid_vec;
  logic [2:0]             inflight;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_empty;
  entry_t                 head;
  logic                   pop;
  logic [XLEN-1:0]        last_pc;

  assign index    = fetch_pc >> 2;
  assign bad_addr = (fetch_pc[1:0] != 2'b00) || (index >= XLEN'(DEPTH));
  assign inflight = count_inflight(pipe_valid_vec);

  // Credit check counts in-flight reads so the FIFO can never overflow.
  assign issue = enable_i && !redirect_i && !halt &&
                 ((32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH));

  assign issue_entry.pc    = fetch_pc;
  assign issue_entry.instr = bad_addr ? NOP_INSTR : mem[index[IW-1:0]];
  assign issue_entry.fault = bad_addr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc <= RESET_PC;
      halt     <= 1'b0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i;
      halt     <= 1'b0;
    end else if (issue) begin
      if (bad_addr) halt <= 1'b1;
      else          fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  generate
    if (READ_LATENCY <= 1) begin : g_direct
      assign wr_valid       = issue;
      assign wr_entry       = issue_entry;
      assign pipe_valid_vec = '0;
    end else begin : g_pipe
      localparam int STAGES = READ_LATENCY - 1;
      logic [STAGES-1:0] pv;
      entry_t            pd [STAGES];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          pv <= '0;
        end else if (redirect_i) begin
          pv <= '0;
        end else begin
          for (int i = STAGES - 1; i > 0; i--) pv[i] <= pv[i-1];
          pv[0] <= issue;
        end
      end

      always_ff @(posedge clk_i) begin
        for (int i = STAGES - 1; i > 0; i--) pd[i] <= pd[i-1];
        pd[0] <= issue_entry;
      end

      assign wr_valid       = pv[STAGES-1];
      assign wr_entry       = pd[STAGES-1];
      assign pipe_valid_vec = {{(MAX_LATENCY-STAGES){1'b0}}, pv};
    end
  endgenerate

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (wr_valid),
    .data_i  (wr_entry),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .data_o  (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign pop = instr_valid_o && instr_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)  last_pc <= '0;
    else if (pop) last_pc <= head.pc;
  end

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_empty ? NOP_INSTR : head.instr;
  assign pc_o          = fifo_empty ? last_pc : head.pc;
  assign fault_o       = !fifo_empty && head.fault;

endmodule
